div_unit: RTL
=============

Name: div_unit

Overview:
- Parametrised iterative radix-2 restoring divider with built-in pipeline control for the EX stage.
- Owns both the start/stall/ready sequencing and the arithmetic; it replaces the separate controller plus external divider pair.
- Handles signed and unsigned modes, any operand width, divide-by-zero, annulment on exception/flush, and result hold while the downstream pipeline is stalled.
- Quotient feeds LO and remainder feeds HI.

Parameters:
WIDTH, 32, operand/result width in bits (must be >= 2)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override)

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
req  input  1  divide instruction present in EX (held high by pipeline while stalled)
is_signed  input  1  1 = DIV semantics, 0 = DIVU; sampled with operands
annul  input  1  flush/exception; cancels any operation
pipe_hold  input  1  downstream stall; EX cannot advance this cycle
dividend  input  WIDTH  rs operand, sampled on acceptance
divisor  input  WIDTH  rt operand, sampled on acceptance
stall  output  1  freeze IF/ID/EX; combinational from state/req/annul
done  output  1  result valid (registered state DONE)
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_zero  output  1  registered, set with done when divisor was 0

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (resetn low, asynchronous):
  - state=IDLE, counter=0.
  - quotient, remainder, done, div_zero all 0.
  - stall=0 once reset has been applied.
- IDLE:
  - If req & !annul: accept. Latch |dividend|, |divisor| (two's-complement magnitude when is_signed, else raw) and the sign bits.
  - If divisor==0: go to DONE, quotient=all-ones, remainder=dividend (raw), div_zero=1.
  - Otherwise go to BUSY, counter=0, partial remainder=0.
  - stall=1 during the accepting cycle.
- BUSY:
  - One quotient bit per cycle, MSB first. Shift partial remainder left by 1 and bring in the next dividend bit. Subtract the divisor magnitude in WIDTH+1 bits; if non-negative, keep the difference and set the quotient bit.
  - Leave after exactly WIDTH cycles. On that edge, apply sign correction:
    - quotient negated if signs differ (signed only);
    - remainder negated if dividend negative (signed only).
  - Then go to DONE. stall=1 throughout.
- DONE:
  - done=1, stall=0, results stable.
  - If pipe_hold=1: stay in DONE and hold results (no restart, even though req is still high).
  - If pipe_hold=0: go to IDLE. req in that same cycle belongs to the instruction now leaving EX and is not re-accepted.
  - The next divide is accepted in IDLE on the following cycle.
- Latency: acceptance edge T; BUSY covers T+1..T+WIDTH; done=1 during cycle T+WIDTH+1. Divide-by-zero has done=1 at T+1.
- annul:
  - Highest priority in every state. Next state is IDLE, counter cleared, done forced 0 next cycle.
  - Registered results keep their last values; no partial update of quotient/remainder is committed.
  - stall=0 in any cycle where annul=1.
- Overflow: signed -2^(WIDTH-1) / -1 gives quotient=-2^(WIDTH-1) (wraps), remainder=0, div_zero=0.
- stall = !annul & ((IDLE & req) | BUSY).
- Operand changes after acceptance are ignored.
- Mid-operation resetn assertion aborts immediately to reset values.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - At acceptance, if divisor!=0 and |dividend| < |divisor| (magnitudes), skip BUSY.
  - Go straight to DONE with quotient=0, remainder=dividend (raw, sign already correct). done=1 at T+1.
  - Divide-by-zero rule unchanged and takes precedence.
- Not defined: every non-zero-divisor operation takes the full WIDTH+1 latency.

Test Plan:
- WIDTH=32, unsigned 0xFFFFFFFF / 0x00000010, req held high -> stall high T..T+32, done at T+33 with quotient=0x0FFFFFFF, remainder=0x0000000F, div_zero=0; no restart the next cycle.
- Signed sign cases:
  - 7 / -2 -> quotient=0xFFFFFFFD, remainder=0x00000001.
  - -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - -7 / -2 -> quotient=0x00000003, remainder=0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; divisor 0 with dividend 0x12345678 -> done at T+1, quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1.
- annul pulsed at T+10 of a 32-bit divide -> stall=0 that cycle, state IDLE next cycle, done never asserted, quotient/remainder unchanged from prior result; new req accepted next cycle completes normally.
- pipe_hold=1 for 3 cycles at DONE -> done and results stable for 4 cycles, stall=0 throughout, then IDLE; a back-to-back second divide starts the cycle after.
- DIV_EARLY_OUT_EN defined, unsigned 3 / 100 -> done at T+1, quotient=0, remainder=3. Same stimulus without the macro -> done at T+33 with the same values.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider with EX-stage start/stall/hold sequencing
//
// Optional build macro: DIV_EARLY_OUT_EN (skip iteration when |dividend| < |divisor|)
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   req        divide instruction present in EX (held while stalled)
//   is_signed  1 = signed divide, 0 = unsigned; sampled with operands
//   annul      flush/exception, cancels any operation
//   pipe_hold  downstream stall, results must be held in DONE
//   dividend   rs operand, sampled on acceptance
//   divisor    rt operand, sampled on acceptance
//   stall      freeze IF/ID/EX (combinational)
//   done       result valid
//   quotient   registered quotient (LO)
//   remainder  registered remainder (HI)
//   div_zero   registered divide-by-zero flag, valid with done

module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             req,
   input  logic             is_signed,
   input  logic             annul,
   input  logic             pipe_hold,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
   logic [WIDTH-1:0] r_aq;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_prem;
   logic             r_neg_q;
   logic             r_neg_r;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_div_zero;

   logic             w_a_neg;
   logic             w_b_neg;
   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic             w_b_zero;
   logic             w_early;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_fits;
   logic [WIDTH-1:0] w_prem_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_last;

   // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
   assign w_a_neg  = is_signed & dividend[WIDTH-1];
   assign w_b_neg  = is_signed & divisor[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -dividend : dividend;
   assign w_b_mag  = w_b_neg ? -divisor  : divisor;
   assign w_b_zero = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
   assign w_early = (w_a_mag < w_b_mag);
`else
   assign w_early = 1'b0;
`endif

   // One restoring step: the extra top bit of the difference is the borrow.
   assign w_shift    = {r_prem, r_aq[WIDTH-1]};
   assign w_diff     = w_shift - {1'b0, r_b};
   assign w_fits     = ~w_diff[WIDTH];
   assign w_prem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_q_nxt    = {r_aq[WIDTH-2:0], w_fits};
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_aq        <= '0;
         r_b         <= '0;
         r_prem      <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div_zero  <= 1'b0;
      end else if (annul) begin
         // Cancel without touching the committed results.
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_aq    <= w_a_mag;
                  r_b     <= w_b_mag;
                  r_prem  <= '0;
                  r_cnt   <= '0;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  if (w_b_zero) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend;
                     r_div_zero  <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (w_early) begin
                     // Quotient is zero, so the raw dividend is already the signed remainder.
                     r_quotient  <= '0;
                     r_remainder <= dividend;
                     r_div_zero  <= 1'b0;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               r_prem <= w_prem_nxt;
               r_aq   <= w_q_nxt;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_quotient  <= r_neg_q ? -w_q_nxt    : w_q_nxt;
                  r_remainder <= r_neg_r ? -w_prem_nxt : w_prem_nxt;
                  r_div_zero  <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               // The req seen here belongs to the instruction leaving EX; never re-accept it.
               if (!pipe_hold) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign stall     = ~annul & (((r_state == S_IDLE) & req) | (r_state == S_BUSY));
   assign done      = (r_state == S_DONE);
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign div_zero  = r_div_zero;

endmodule
